adc_pair_averager: RTL and testbench

Dual-channel boxcar averager and decimator downstream of the PmodAD1 capture wrapper. Each `in_valid` strobe, it takes one 12-bit sample pair, accumulates 2^LOG2_N pairs, and emits the per-channel mean plus per-window min/max through a valid/ready output register. It gives downstream consumers (display, UART logger) a lower-rate, noise-reduced sample stream without touching the ADC serial timing.

---
 rtl/adc_pkg.sv | 12 +
 rtl/adc_chan_stats.sv | 50 +++++
 rtl/adc_pair_averager.sv | 127 ++++++++++++
 tb/tb_adc_pair_averager.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the PmodAD1 data path: sample width and the
// window FSM states used by the pair averager.
package adc_pkg;

    localparam int ADC_W = 12;

    typedef enum logic {
        FIRST = 1'b0,
        ACCUM = 1'b1
    } win_state_t;

endpackage

// File: rtl/adc_chan_stats.sv
// One channel's window statistics: running sum plus min/max, together with
// the values they take after the sample presented this cycle.
module adc_chan_stats
    import adc_pkg::*;
#(
    parameter int LOG2_N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_first,
    input  logic                     add,
    input  logic                     clr,
    input  logic [ADC_W-1:0]         sample,
    output logic [ADC_W+LOG2_N-1:0]  sum_next,
    output logic [ADC_W-1:0]         min_next,
    output logic [ADC_W-1:0]         max_next
);

    localparam int ACC_W = ADC_W + LOG2_N;

    logic [ACC_W-1:0] acc_q;
    logic [ADC_W-1:0] min_q;
    logic [ADC_W-1:0] max_q;

    // Strict compares so a tie keeps the value already held.
    always_comb begin
        sum_next = load_first ? ACC_W'(sample) : acc_q + ACC_W'(sample);
        min_next = (load_first || sample < min_q) ? sample : min_q;
        max_next = (load_first || sample > max_q) ? sample : max_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else if (load_first || add) begin
            acc_q <= sum_next;
            min_q <= min_next;
            max_q <= max_next;
        end
    end

endmodule

// File: rtl/adc_pair_averager.sv
// Dual-channel boxcar averager/decimator: averages 2^LOG2_N sample pairs and
// presents mean, min and max per channel through a valid/ready register.
module adc_pair_averager
    import adc_pkg::*;
#(
    parameter int LOG2_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [ADC_W-1:0] in_data0,
    input  logic [ADC_W-1:0] in_data1,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADC_W-1:0] out_avg0,
    output logic [ADC_W-1:0] out_avg1,
    output logic [ADC_W-1:0] out_min0,
    output logic [ADC_W-1:0] out_min1,
    output logic [ADC_W-1:0] out_max0,
    output logic [ADC_W-1:0] out_max1,
    output logic             overrun
);

    localparam int ACC_W = ADC_W + LOG2_N;
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);
    localparam bit PASS_THRU = (LOG2_N == 0);

    win_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             load_first;
    logic             add;
    logic             complete;
    logic             out_load;

    logic [ACC_W-1:0] sum0, sum1;
    logic [ADC_W-1:0] min0, min1, max0, max1;
    logic [ADC_W-1:0] avg0, avg1;

    // NOTE: every combinational output gets a value on every path so no
    // latch is inferred.
    always_comb begin
        accept     = in_valid && !clear;
        load_first = accept && (state == FIRST);
        add        = accept && (state == ACCUM);
        complete   = PASS_THRU ? load_first : (add && cnt == CNT_LAST);
        out_load   = complete && (!out_valid || out_ready);
        avg0       = ADC_W'(sum0 >> LOG2_N);
        avg1       = ADC_W'(sum1 >> LOG2_N);
    end

    adc_chan_stats #(.LOG2_N(LOG2_N)) u_chan0 (
        .clk        (clk),
        .rst        (rst),
        .load_first (load_first),
        .add        (add),
        .clr        (clear),
        .sample     (in_data0),
        .sum_next   (sum0),
        .min_next   (min0),
        .max_next   (max0)
    );

    adc_chan_stats #(.LOG2_N(LOG2_N)) u_chan1 (
        .clk        (clk),
        .rst        (rst),
        .load_first (load_first),
        .add        (add),
        .clr        (clear),
        .sample     (in_data1),
        .sum_next   (sum1),
        .min_next   (min1),
        .max_next   (max1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FIRST;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_avg0  <= '0;
            out_avg1  <= '0;
            out_min0  <= '0;
            out_min1  <= '0;
            out_max0  <= '0;
            out_max1  <= '0;
            overrun   <= 1'b0;
        end else begin
            // Window control; a clear restarts the window and drops the sample.
            if (clear) begin
                state <= FIRST;
                cnt   <= '0;
            end else if (complete) begin
                state <= FIRST;
                cnt   <= '0;
            end else if (load_first) begin
                state <= ACCUM;
                cnt   <= CNT_W'(1);
            end else if (add) begin
                cnt   <= cnt + CNT_W'(1);
            end

            // Result register survives clear; a blocked result is lost.
            if (out_load) begin
                out_valid <= 1'b1;
                out_avg0  <= avg0;
                out_avg1  <= avg1;
                out_min0  <= min0;
                out_min1  <= min1;
                out_max0  <= max0;
                out_max1  <= max1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (clear) begin
                overrun <= 1'b0;
            end else if (complete && !out_load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_pair_averager.sv
// Directed bench: a LOG2_N=2 instance (a_*) and a pass-through LOG2_N=0
// instance (b_*) sharing clock, reset, data, clear and out_ready.
module tb_adc_pair_averager;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        out_ready;
    logic [11:0] in_data0;
    logic [11:0] in_data1;
    logic        a_in_valid;
    logic        b_in_valid;

    logic        a_out_valid, a_overrun;
    logic [11:0] a_avg0, a_avg1, a_min0, a_min1, a_max0, a_max1;
    logic        b_out_valid, b_overrun;
    logic [11:0] b_avg0, b_avg1, b_min0, b_min1, b_max0, b_max1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adc_pair_averager #(.LOG2_N(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .clear     (clear),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_avg0  (a_avg0),
        .out_avg1  (a_avg1),
        .out_min0  (a_min0),
        .out_min1  (a_min1),
        .out_max0  (a_max0),
        .out_max1  (a_max1),
        .overrun   (a_overrun)
    );

    adc_pair_averager #(.LOG2_N(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .clear     (clear),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_avg0  (b_avg0),
        .out_avg1  (b_avg1),
        .out_min0  (b_min0),
        .out_min1  (b_min1),
        .out_max0  (b_max0),
        .out_max1  (b_max1),
        .overrun   (b_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [11:0] d0, input logic [11:0] d1);
        a_in_valid = 1'b1;
        in_data0   = d0;
        in_data1   = d1;
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic feed_b(input logic [11:0] d0);
        b_in_valid = 1'b1;
        in_data0   = d0;
        in_data1   = 12'd0;
        step();
        b_in_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        clear      = 1'b0;
        out_ready  = 1'b0;
        in_data0   = '0;
        in_data1   = '0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        step();
        step();

        check("rst_valid",   a_out_valid, 0);
        check("rst_overrun", a_overrun,   0);
        check("rst_avg0",    a_avg0,      0);
        check("rst_max1",    a_max1,      0);
        check("rst_b_valid", b_out_valid, 0);
        rst = 1'b0;
        step();

        // Basic window, ready high.
        out_ready = 1'b1;
        feed_a(12'd100, 12'd4095);
        feed_a(12'd200, 12'd4095);
        feed_a(12'd300, 12'd4095);
        check("pre_complete_valid", a_out_valid, 0);
        feed_a(12'd400, 12'd4095);
        check("win1_valid", a_out_valid, 1);
        check("win1_avg0",  a_avg0, 250);
        check("win1_min0",  a_min0, 100);
        check("win1_max0",  a_max0, 400);
        check("win1_avg1",  a_avg1, 4095);
        check("win1_min1",  a_min1, 4095);
        check("win1_max1",  a_max1, 4095);
        step();
        check("win1_pulse_end", a_out_valid, 0);

        // Truncating average.
        feed_a(12'd1, 12'd0);
        feed_a(12'd1, 12'd0);
        feed_a(12'd1, 12'd0);
        feed_a(12'd2, 12'd0);
        check("trunc_valid", a_out_valid, 1);
        check("trunc_avg0",  a_avg0, 1);
        check("trunc_max0",  a_max0, 2);
        step();

        // Backpressure across two windows: second result lost.
        out_ready = 1'b0;
        feed_a(12'd10, 12'd5);
        feed_a(12'd20, 12'd5);
        feed_a(12'd30, 12'd5);
        feed_a(12'd40, 12'd5);
        check("bp_first_valid", a_out_valid, 1);
        check("bp_first_avg0",  a_avg0, 25);
        feed_a(12'd50, 12'd7);
        feed_a(12'd60, 12'd7);
        feed_a(12'd70, 12'd7);
        feed_a(12'd80, 12'd7);
        check("bp_hold_avg0",   a_avg0, 25);
        check("bp_hold_avg1",   a_avg1, 5);
        check("bp_hold_max0",   a_max0, 40);
        check("bp_overrun",     a_overrun, 1);
        out_ready = 1'b1;
        step();
        check("bp_drained",        a_out_valid, 0);
        check("bp_overrun_sticky", a_overrun, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("bp_overrun_cleared", a_overrun, 0);

        // Completion coincident with a drain handshake.
        out_ready = 1'b0;
        feed_a(12'd8, 12'd1);
        feed_a(12'd8, 12'd1);
        feed_a(12'd8, 12'd1);
        feed_a(12'd8, 12'd1);
        feed_a(12'd16, 12'd2);
        feed_a(12'd16, 12'd2);
        feed_a(12'd16, 12'd2);
        check("dr_pending_avg0", a_avg0, 8);
        out_ready = 1'b1;
        feed_a(12'd16, 12'd2);
        check("dr_valid",   a_out_valid, 1);
        check("dr_avg0",    a_avg0, 16);
        check("dr_avg1",    a_avg1, 2);
        check("dr_overrun", a_overrun, 0);
        step();
        check("dr_drained", a_out_valid, 0);

        // Clear mid-window, then clear coincident with in_valid.
        feed_a(12'd1000, 12'd1000);
        feed_a(12'd1000, 12'd1000);
        clear = 1'b1;
        step();
        a_in_valid = 1'b1;
        in_data0   = 12'd4000;
        in_data1   = 12'd4000;
        step();
        a_in_valid = 1'b0;
        clear      = 1'b0;
        feed_a(12'd10, 12'd3);
        feed_a(12'd20, 12'd3);
        feed_a(12'd30, 12'd3);
        check("clr_no_early", a_out_valid, 0);
        feed_a(12'd40, 12'd3);
        check("clr_valid", a_out_valid, 1);
        check("clr_avg0",  a_avg0, 25);
        check("clr_min0",  a_min0, 10);
        check("clr_max0",  a_max0, 40);
        step();

        // Pass-through, back-to-back strobes.
        b_in_valid = 1'b1;
        in_data0   = 12'd7;
        step();
        check("pt_valid_7", b_out_valid, 1);
        check("pt_avg_7",   b_avg0, 7);
        in_data0 = 12'd8;
        step();
        check("pt_valid_8", b_out_valid, 1);
        check("pt_avg_8",   b_avg0, 8);
        check("pt_min_8",   b_min0, 8);
        in_data0 = 12'd9;
        step();
        check("pt_valid_9", b_out_valid, 1);
        check("pt_avg_9",   b_avg0, 9);
        check("pt_max_9",   b_max0, 9);
        check("pt_overrun", b_overrun, 0);
        b_in_valid = 1'b0;
        step();
        check("pt_drained", b_out_valid, 0);

        // Async reset with a pending result and a half-filled window.
        out_ready = 1'b0;
        feed_b(12'd5);
        feed_a(12'd900, 12'd900);
        feed_a(12'd900, 12'd900);
        check("ar_b_pending", b_avg0, 5);
        #2;
        rst = 1'b1;
        #1;
        check("ar_b_valid", b_out_valid, 0);
        check("ar_b_avg0",  b_avg0, 0);
        check("ar_a_avg0",  a_avg0, 0);
        check("ar_a_min0",  a_min0, 0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        feed_a(12'd100, 12'd200);
        feed_a(12'd100, 12'd200);
        feed_a(12'd100, 12'd200);
        feed_a(12'd100, 12'd200);
        check("ar_fresh_avg0", a_avg0, 100);
        check("ar_fresh_avg1", a_avg1, 200);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
